// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B snoop path: frame FSM states and line
// timing constants used by the decoder and the frame controller.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    RECEIVE
  } frame_state_t;

  localparam int PIXEL_BITS           = 24;
  localparam int DEFAULT_RESET_CYCLES = 3200;
  // High-time split point between a 0 bit (~0.4 us) and a 1 bit (~0.8 us) at 64 MHz
  localparam int THRESHOLD            = 38;

endpackage

// File: rtl/ws2812b_gap_detector.sv
// Synchronizes the raw line and flags a latch gap: one pulse when the line
// has been low for RESET_CYCLES consecutive cycles, re-armed by any high.
module ws2812b_gap_detector
  import ws2812b_pkg::*;
#(
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic gap
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] low_cnt_reg;
  logic          gap_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg    <= '0;
      low_cnt_reg <= '0;
      gap_reg     <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], din};
      if (sync_reg[1]) begin
        low_cnt_reg <= '0;
      end else if (low_cnt_reg != CW'(RESET_CYCLES)) begin
        low_cnt_reg <= low_cnt_reg + CW'(1);
      end
      // Fires in the same cycle the counter lands on RESET_CYCLES; saturation blocks re-fire
      gap_reg <= !sync_reg[1] && (low_cnt_reg == CW'(RESET_CYCLES - 1));
    end
  end

  assign gap = gap_reg;

endmodule

// File: rtl/ws2812b_frame_ctrl.sv
// Frame-level WS2812B controller: assembles decoded bits into GRB words,
// captures the word at a chosen chain position and reports frame status.
module ws2812b_frame_ctrl
  import ws2812b_pkg::*;
#(
  parameter int CLK_HZ       = 64000000,
  parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
  parameter int IDX_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             bit_valid,
  input  logic             bit_value,
  input  logic             enable,
  input  logic [IDX_W-1:0] target_index,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic [IDX_W-1:0] pixel_count,
  output logic             frame_active,
  output logic             frame_done,
  output logic             err_partial
);

  localparam int BCW = $clog2(PIXEL_BITS);

  if (RESET_CYCLES < 2 || CLK_HZ < 1) begin : g_param_check
    $error("ws2812b_frame_ctrl: RESET_CYCLES must be >= 2 and CLK_HZ positive");
  end

  logic gap;

  ws2812b_gap_detector #(
    .RESET_CYCLES(RESET_CYCLES)
  ) u_gap (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .gap  (gap)
  );

  frame_state_t            state_reg;
  // Only 23 bits are kept: the completing bit is taken straight from bit_value
  logic [PIXEL_BITS-2:0]   shreg_reg;
  logic [BCW-1:0]          bit_cnt_reg;
  logic [IDX_W-1:0]        pix_idx_reg;
  logic [IDX_W-1:0]        target_reg;
  logic [23:0]             pixel_data_reg;
  logic                    pixel_valid_reg;
  logic [IDX_W-1:0]        pixel_count_reg;
  logic                    frame_active_reg;
  logic                    frame_done_reg;
  logic                    err_partial_reg;

  logic                    word_done;
  logic [BCW-1:0]          bit_cnt_next;

  assign word_done    = bit_valid && (bit_cnt_reg == BCW'(PIXEL_BITS - 1));
  assign bit_cnt_next = !bit_valid ? bit_cnt_reg :
                        word_done  ? '0 : bit_cnt_reg + BCW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= SYNC;
      shreg_reg        <= '0;
      bit_cnt_reg      <= '0;
      pix_idx_reg      <= '0;
      target_reg       <= '0;
      pixel_data_reg   <= '0;
      pixel_valid_reg  <= 1'b0;
      pixel_count_reg  <= '0;
      frame_active_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      err_partial_reg  <= 1'b0;
    end else begin
      pixel_valid_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      if (!enable) begin
        state_reg        <= SYNC;
        frame_active_reg <= 1'b0;
      end else begin
        case (state_reg)
          SYNC: begin
            if (gap) state_reg <= IDLE;
          end
          IDLE: begin
            if (bit_valid) begin
              target_reg       <= target_index;
              pixel_count_reg  <= '0;
              pix_idx_reg      <= '0;
              err_partial_reg  <= 1'b0;
              shreg_reg        <= {{(PIXEL_BITS-2){1'b0}}, bit_value};
              bit_cnt_reg      <= BCW'(1);
              frame_active_reg <= 1'b1;
              state_reg        <= RECEIVE;
            end
          end
          RECEIVE: begin
            if (bit_valid) begin
              shreg_reg   <= {shreg_reg[PIXEL_BITS-3:0], bit_value};
              bit_cnt_reg <= bit_cnt_next;
              if (word_done) begin
                if (pixel_count_reg != '1) pixel_count_reg <= pixel_count_reg + IDX_W'(1);
                if (pix_idx_reg != '1) pix_idx_reg <= pix_idx_reg + IDX_W'(1);
                if (pix_idx_reg == target_reg) begin
                  pixel_data_reg  <= {shreg_reg, bit_value};
                  pixel_valid_reg <= 1'b1;
                end
              end
            end
            // A gap in the same cycle closes the frame after the bit is accounted for
            if (gap) begin
              frame_done_reg   <= 1'b1;
              frame_active_reg <= 1'b0;
              err_partial_reg  <= (bit_cnt_next != '0);
              bit_cnt_reg      <= '0;
              shreg_reg        <= '0;
              state_reg        <= IDLE;
            end
          end
          default: state_reg <= SYNC;
        endcase
      end
    end
  end

  assign pixel_data   = pixel_data_reg;
  assign pixel_valid  = pixel_valid_reg;
  assign pixel_count  = pixel_count_reg;
  assign frame_active = frame_active_reg;
  assign frame_done   = frame_done_reg;
  assign err_partial  = err_partial_reg;

endmodule

// File: doc/ws2812b_frame_ctrl.md
Name: ws2812b_frame_ctrl

Overview:
Frame-level controller placed after the WS2812B pulse decoder in the LED-snoop peripheral. Consumes the decoder's per-bit strobes plus the raw line, detects the >=50 us latch gap, and assembles bits into 24-bit GRB pixel words. Selects the pixel at a programmable chain position and counts pixels per frame. Reports frame boundaries and framing errors to the register interface.

Parameters:
CLK_HZ, 64000000, system clock frequency (documentation only; gap length is set by RESET_CYCLES)
RESET_CYCLES, 3200, consecutive low cycles that constitute a latch gap (50 us at 64 MHz)
IDX_W, 8, width of pixel index and pixel counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
din  input  1  raw WS2812B line (same net feeding the decoder)
bit_valid  input  1  one-cycle decoded-bit strobe from decoder
bit_value  input  1  decoded bit, valid with bit_valid
enable  input  1  block enable from register file
target_index  input  IDX_W  chain position of pixel to capture (0 = first pixel)
pixel_data  output  24  captured GRB word, G[23:16] R[15:8] B[7:0], first-received bit in MSB
pixel_valid  output  1  one-cycle strobe: pixel_data updated
pixel_count  output  IDX_W  completed pixels in current/last frame, saturating
frame_active  output  1  high from first bit of a frame until its latch gap
frame_done  output  1  one-cycle strobe on latch gap closing a frame
err_partial  output  1  last frame ended with an incomplete word; sticky until next frame start

Behaviour:
- Reset: every output is 0; state SYNC; shift register, bit counter, pixel index and low counter are 0.
- din passes through a 2-flop synchronizer inside this block. The low counter increments while the synchronized din is 0, saturates at RESET_CYCLES, and clears on any 1. "gap" is a single-cycle event on the cycle the counter reaches RESET_CYCLES. It does not re-fire until din has gone high again.
- States: SYNC, IDLE, RECEIVE.
- SYNC: ignore bit_valid. On gap with enable=1, go to IDLE. Guarantees alignment after reset or after joining a stream mid-frame.
- IDLE: on bit_valid with enable=1, do all of the following, then go to RECEIVE:
  - latch target_index;
  - clear pixel_count, pixel index and err_partial;
  - shift in the bit, set bit_cnt=1;
  - set frame_active=1.
- RECEIVE, bit_valid: shreg <= {shreg[22:0], bit_value}, bit_cnt++. When bit_cnt was 23, the word is complete:
  - bit_cnt <= 0;
  - pixel_count++ (saturates at 2^IDX_W-1);
  - pixel index++ (saturates);
  - if the pixel index before the increment equals the latched target, pixel_data <= completed word and pixel_valid pulses.
  - pixel_data and pixel_valid update on the clock edge after the completing bit_valid, i.e. 1-cycle latency.
- RECEIVE, gap: frame_done pulses for one cycle and frame_active goes 0. err_partial <= (bit_cnt != 0). Discard the partial word. Go to IDLE.
- bit_valid and gap in the same cycle: process the bit first (it may complete a word and fire pixel_valid), then close the frame using the updated bit_cnt. pixel_valid and frame_done may be high together.
- target_index >= number of pixels in the frame: no pixel_valid that frame; pixel_data holds its previous value.
- enable deasserted in any state: next state is SYNC. frame_active goes 0, no frame_done is issued, and pixel_data, pixel_count and err_partial hold. Re-enabling requires a fresh gap.
- Asynchronous reset mid-frame: outputs clear immediately, then resynchronize via SYNC.
- target_index changes mid-frame have no effect until the next frame start.

Decomposition:
- Shared package ws2812b_pkg holds:
  - the frame state enum (SYNC/IDLE/RECEIVE);
  - PIXEL_BITS=24;
  - default RESET_CYCLES;
  - the decoder THRESHOLD constant.
- Sub-module ws2812b_gap_detector contains the synchronizer, the saturating low counter and the gap pulse. It is parameterized by RESET_CYCLES, with counter width $clog2(RESET_CYCLES+1).
- The controller does not instantiate the pulse decoder; the peripheral top wires the two together.

Test Plan (sim with RESET_CYCLES=64 unless noted):
- Reset release, then a 70-cycle low gap, then 3 pixels 0x123456, 0xABCDEF, 0x00FF00 (target_index=1), then a gap -> one pixel_valid with pixel_data=0xABCDEF; frame_done once; pixel_count=3; err_partial=0.
- Stream starts mid-frame (30 bits with no prior gap), then a gap, then 1 pixel 0xFFFFFF (target 0) -> the first 30 bits are ignored; pixel_data=0xFFFFFF; pixel_count=1.
- 2 pixels plus 10 extra bits, then a gap -> pixel_count=2, err_partial=1, frame_done pulses; the next frame's first bit clears err_partial to 0.
- target_index=5 with a 3-pixel frame -> no pixel_valid; pixel_data keeps its old value; pixel_count=3.
- 24th bit's bit_valid forced in the same cycle as the gap -> pixel_valid and frame_done in the same cycle; pixel_count=1; err_partial=0.
- enable dropped after 12 bits, raised again, new gap, 1 pixel 0x0A0B0C -> no frame_done for the aborted frame; the next frame captures 0x0A0B0C. Async reset asserted mid-word -> all outputs read 0 within the same cycle.
